// File: rtl/vga_plot_receiver.sv
// Plot-bus receiver: buffers {x,y,RGB} plot requests in a FIFO, converts them to
// linear framebuffer writes, drops and counts off-screen plots, and runs full-screen clears.
module vga_plot_receiver #(
   parameter int FIFO_DEPTH = 8,
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 120,
   parameter int ADDR_W     = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        vga_x_in_bus,
   input  logic [7:0]        vga_y_in_bus,
   input  logic [23:0]       vga_RGB_in_bus,
   input  logic              vga_draw_enable_bus,
   output logic              ready,
   input  logic              clear_start,
   input  logic [23:0]       clear_colour,
   output logic              clear_done,
   output logic [ADDR_W-1:0] fb_address,
   output logic [23:0]       fb_data,
   output logic              fb_write_enable,
   output logic [7:0]        dropped_count,
   output logic              busy
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [ADDR_W-1:0] W_A       = ADDR_W'(SCREEN_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

   typedef enum logic {S_RUN, S_CLEAR} state_t;

   state_t            r_state, w_state_next;
   logic [39:0]       r_fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              r_clear_pending;
   logic [23:0]       r_clear_colour;
   logic [ADDR_W-1:0] r_clear_cnt;
   logic [ADDR_W-1:0] r_fb_address;
   logic [23:0]       r_fb_data;
   logic              r_fb_we;
   logic              r_clear_done;
   logic [7:0]        r_dropped;

   logic              w_ready, w_push, w_pop, w_clear_accept, w_onscreen;
   logic [39:0]       w_head;
   logic [7:0]        w_head_x, w_head_y;
   logic [ADDR_W-1:0] w_lin_addr;

   // Ready looks only at the registered count, so a full FIFO refuses a push even while popping.
   assign w_ready        = (r_state == S_RUN) && !r_clear_pending && (32'(r_count) < FIFO_DEPTH);
   assign w_push         = vga_draw_enable_bus && w_ready;
   assign w_pop          = (r_state == S_RUN) && (r_count != '0);
   assign w_clear_accept = clear_start && (r_state == S_RUN) && !r_clear_pending;

   assign w_head     = r_fifo_mem[r_rd_ptr];
   assign w_head_x   = w_head[39:32];
   assign w_head_y   = w_head[31:24];
   assign w_onscreen = (32'(w_head_x) < SCREEN_W) && (32'(w_head_y) < SCREEN_H);
   assign w_lin_addr = ADDR_W'(w_head_y) * W_A + ADDR_W'(w_head_x);

   always_ff @(posedge clk) begin
      if (w_push)
         r_fifo_mem[r_wr_ptr] <= {vga_x_in_bus, vga_y_in_bus, vga_RGB_in_bus};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_RUN;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_RUN:   if (r_clear_pending && (r_count == '0)) w_state_next = S_CLEAR;
         S_CLEAR: if (r_clear_cnt == LAST_ADDR)           w_state_next = S_RUN;
         default: w_state_next = S_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fb_address    <= '0;
         r_fb_data       <= '0;
         r_fb_we         <= 1'b0;
         r_clear_done    <= 1'b0;
         r_dropped       <= '0;
         r_clear_pending <= 1'b0;
         r_clear_colour  <= '0;
         r_clear_cnt     <= '0;
      end else begin
         r_clear_done <= 1'b0;
         if (w_clear_accept) begin
            r_clear_pending <= 1'b1;
            r_clear_colour  <= clear_colour;
         end
         case (r_state)
            S_RUN: begin
               if (w_pop) begin
                  if (w_onscreen) begin
                     r_fb_address <= w_lin_addr;
                     r_fb_data    <= w_head[23:0];
                     r_fb_we      <= 1'b1;
                  end else begin
                     r_fb_we <= 1'b0;
                     if (r_dropped != 8'hFF) r_dropped <= r_dropped + 1'b1;
                  end
               end else begin
                  r_fb_we <= 1'b0;
                  // FIFO is empty here, so a pending clear starts on this edge.
                  if (r_clear_pending) begin
                     r_clear_pending <= 1'b0;
                     r_clear_cnt     <= '0;
                  end
               end
            end
            S_CLEAR: begin
               r_fb_address <= r_clear_cnt;
               r_fb_data    <= r_clear_colour;
               r_fb_we      <= 1'b1;
               r_clear_cnt  <= r_clear_cnt + 1'b1;
               if (r_clear_cnt == LAST_ADDR) r_clear_done <= 1'b1;
            end
            default: r_fb_we <= 1'b0;
         endcase
      end
   end

   assign ready           = w_ready && !reset;
   assign fb_address      = r_fb_address;
   assign fb_data         = r_fb_data;
   assign fb_write_enable = r_fb_we;
   assign clear_done      = r_clear_done;
   assign dropped_count   = r_dropped;
   assign busy            = (r_count != '0) || r_clear_pending || (r_state == S_CLEAR) || r_fb_we;

endmodule

// File: tb/tb_vga_plot_receiver.sv
// Directed bench for vga_plot_receiver: plots, drops, saturation, clear and reset-abandoned clear.
module tb_vga_plot_receiver;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  x_in = '0, y_in = '0;
   logic [23:0] rgb_in = '0;
   logic        en = 1'b0;
   logic        ready;
   logic        clear_start = 1'b0;
   logic [23:0] clear_colour = '0;
   logic        clear_done;
   logic [14:0] fb_address;
   logic [23:0] fb_data;
   logic        fb_write_enable;
   logic [7:0]  dropped_count;
   logic        busy;

   vga_plot_receiver dut (
      .clk(clk), .reset(reset),
      .vga_x_in_bus(x_in), .vga_y_in_bus(y_in), .vga_RGB_in_bus(rgb_in),
      .vga_draw_enable_bus(en), .ready(ready),
      .clear_start(clear_start), .clear_colour(clear_colour), .clear_done(clear_done),
      .fb_address(fb_address), .fb_data(fb_data), .fb_write_enable(fb_write_enable),
      .dropped_count(dropped_count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] a;
      logic [23:0] d;
      int          c;
      logic        dn;
   } wr_t;

   wr_t wq[$];
   int  cyc = 0;
   int  acc_cyc = 0;
   int  done_cnt = 0;
   int  n_pass = 0;
   int  n_total = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fb_write_enable) wq.push_back('{fb_address, fb_data, cyc, clear_done});
      if (clear_done) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [23:0] rgb,
                       input bit chk_ready);
      int t = 0;
      @(negedge clk);
      x_in = x; y_in = y; rgb_in = rgb; en = 1'b1;
      if (chk_ready) check("t2_ready", ready, 1);
      while (!ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!ready) check("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int first_acc;
      int errs;
      int t;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_addr", fb_address, 0);
      check("rst_we", fb_write_enable, 0);
      check("rst_data", fb_data, 0);
      check("rst_drop", dropped_count, 0);
      check("rst_ready", ready, 0);
      check("rst_done", clear_done, 0);
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", ready, 1);
      check("post_rst_busy", busy, 0);

      // 1: single plot
      wq.delete();
      send(8'd5, 8'd2, 24'hFF0000, 0);
      idle(6);
      check("t1_nwr", wq.size(), 1);
      if (wq.size() >= 1) begin
         check("t1_addr", wq[0].a, 325);
         check("t1_data", wq[0].d, 24'hFF0000);
         check("t1_latency", wq[0].c, acc_cyc + 1);
      end
      check("t1_drop", dropped_count, 0);

      // 2: 12-plot stream
      wq.delete();
      first_acc = 0;
      for (int i = 0; i < 12; i++) begin
         send(8'(10 + i), 8'd3, 24'(i + 1), 1);
         if (i == 0) first_acc = acc_cyc;
      end
      idle(6);
      check("t2_nwr", wq.size(), 12);
      errs = 0;
      if (wq.size() == 12) begin
         for (int i = 0; i < 12; i++) begin
            if (wq[i].a != 15'(490 + i) || wq[i].d != 24'(i + 1) || wq[i].c != first_acc + 1 + i)
               errs++;
         end
      end
      check("t2_order", errs, 0);

      // 3: off-screen drops
      wq.delete();
      send(8'd160, 8'd0, 24'h111111, 0);
      send(8'd0, 8'd120, 24'h222222, 0);
      send(8'd159, 8'd119, 24'h333333, 0);
      idle(6);
      check("t3_drop", dropped_count, 2);
      check("t3_nwr", wq.size(), 1);
      if (wq.size() >= 1) begin
         check("t3_addr", wq[0].a, 19199);
         check("t3_data", wq[0].d, 24'h333333);
      end

      // 4: plots then full-screen clear
      wq.delete();
      done_cnt = 0;
      for (int i = 0; i < 7; i++) send(8'(i), 8'd1, 24'(8'hA0 + i), 0);
      @(negedge clk);
      x_in = 8'd7; y_in = 8'd1; rgb_in = 24'hA7; en = 1'b1;
      clear_start = 1'b1; clear_colour = 24'h0000FF;
      check("t4_ready_at_start", ready, 1);
      @(posedge clk);
      #1;
      clear_start = 1'b0; en = 1'b0;
      @(negedge clk);
      check("t4_ready_fell", ready, 0);
      t = 0;
      while (!clear_done && t < 25000) begin
         @(negedge clk);
         t++;
      end
      check("t4_done_seen", clear_done, 1);
      check("t4_done_addr", fb_address, 19199);
      check("t4_done_we", fb_write_enable, 1);
      @(negedge clk);
      check("t4_ready_back", ready, 1);
      idle(4);
      check("t4_nwr", wq.size(), 19208);
      errs = 0;
      if (wq.size() == 19208) begin
         for (int i = 0; i < 8; i++)
            if (wq[i].a != 15'(160 + i) || wq[i].d != 24'(8'hA0 + i) || wq[i].dn) errs++;
         for (int j = 8; j < 19208; j++)
            if (wq[j].a != 15'(j - 8) || wq[j].d != 24'h0000FF || wq[j].dn != (j == 19207)) errs++;
      end
      check("t4_seq", errs, 0);
      check("t4_done_cnt", done_cnt, 1);
      check("t4_busy", busy, 0);

      // 5: drop counter saturation
      for (int i = 0; i < 100; i++) send(8'd200, 8'd5, 24'h0, 0);
      idle(6);
      check("t5_drop_102", dropped_count, 102);
      for (int i = 0; i < 200; i++) send(8'd7, 8'd200, 24'h0, 0);
      idle(6);
      check("t5_drop_sat", dropped_count, 255);

      // 6: reset during clear
      @(negedge clk);
      clear_start = 1'b1; clear_colour = 24'h123456;
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      done_cnt = 0;
      repeat (9000) @(negedge clk);
      check("t6_mid_we", fb_write_enable, 1);
      reset = 1'b1;
      #1;
      check("t6_rst_we", fb_write_enable, 0);
      check("t6_rst_addr", fb_address, 0);
      check("t6_rst_data", fb_data, 0);
      check("t6_rst_drop", dropped_count, 0);
      check("t6_rst_ready", ready, 0);
      check("t6_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (11000) @(negedge clk);
      check("t6_no_done", done_cnt, 0);
      check("t6_idle_busy", busy, 0);
      wq.delete();
      send(8'd0, 8'd0, 24'h777777, 0);
      idle(6);
      check("t6_nwr", wq.size(), 1);
      if (wq.size() >= 1) begin
         check("t6_addr", wq[0].a, 0);
         check("t6_data", wq[0].d, 24'h777777);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
